reg_serial_tx: RTL and testbench
================================

REG_SERIAL_TX -- requirements
Module: reg_serial_tx

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning data word width in bits (legal N >= 1).
REQ-002 The block SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (legal DIV >= 1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port load  input  1  request to transmit d.
REQ-006 The block SHALL have port d  input  N  parallel word to transmit.
REQ-007 The block SHALL have port ready  output  1  high when a load will be accepted.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-013 Accept: at a rising edge where load && ready, d SHALL be captured into an internal shift register and the state SHALL go to START.
REQ-014 load while not ready SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-015 Changes on d after accept SHALL NOT affect the frame.
REQ-016 Frame: START drives tx=0 for DIV cycles; DATA drives N bits MSB-first, DIV cycles each; STOP drives tx=1 for DIV cycles.
REQ-017 tx SHALL be registered and SHALL change only on the bit-period boundaries.
REQ-018 The first start-bit cycle on tx SHALL be the cycle after accept; total frame length SHALL be exactly (N+2)*DIV cycles.
REQ-019 An internal bit timer SHALL count 0..DIV-1 and SHALL wrap to 0 at the end of each bit period; it SHALL be held at 0 in IDLE.
REQ-020 An internal bit index SHALL count 0..N-1 in DATA; after bit N-1 completes, the state SHALL go to STOP.
REQ-021 At STOP completion, the state SHALL return to IDLE and done SHALL be high for exactly that first IDLE cycle.
REQ-022 Back-to-back: load asserted in the done cycle SHALL be accepted, leaving zero idle bit periods between frames.
REQ-023 DIV=1 SHALL work, with one clock per bit and the timer degenerate.
REQ-024 N=1 SHALL work, producing a 3-bit frame.
REQ-025 In IDLE, tx SHALL be 1.

Reset
REQ-026 clr_n low SHALL immediately, without waiting for clk, force state=IDLE, tx=1, done=0, timer=0, index=0 and shift register=0.
REQ-027 After reset the outputs SHALL be ready=1, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse; no partial resume SHALL occur after release.
REQ-029 The first accept SHALL be possible at the first rising edge after clr_n deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef/encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default N and DIV constants.
REQ-031 One sub-module, bit_timer (parameter DIV; ports clk, clr_n, run, tick), SHALL produce tick on the last cycle of each bit period.
REQ-032 The FSM, shift register and index SHALL live in reg_serial_tx.

Verification
REQ-033 Reset release, then load 0xA5 (N=8, DIV=4) -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses 40 cycles after accept; ready high with done.
REQ-034 During the 0xA5 frame, load=1 with d=0xFF held throughout -> frame unchanged; exactly one done.
REQ-035 load 0x3C accepted in the done cycle of a prior frame -> new start bit in the next cycle; no idle gap; two done pulses 40 cycles apart.
REQ-036 clr_n pulsed low in the middle of DATA -> tx=1 and ready=1 without a clock edge; no done; next load 0x01 transmits a clean frame.
REQ-037 DIV=1, N=1, load d=1 -> tx = 0,1,1 for one cycle each; done on the 3rd cycle after accept.
REQ-038 load=0 held for 100 cycles after reset -> tx=1, done=0, busy=0 throughout.

Source files
------------

// File: rtl/reg_serial_tx_pkg.sv
// Shared types and constants for the register-loaded serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, default word width / bit period, and a
// counter-width helper that stays legal for degenerate sizes (1).
package reg_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int N_DEFAULT   = 8;
  localparam int DIV_DEFAULT = 4;

  // Width of a counter holding 0..n-1; never returns 0 so vectors stay legal.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while run is high, pulses tick on the last cycle.
// Latency: tick is combinational from the count register; first tick DIV-1 cycles after run rises.
// Backpressure: none; run=0 holds the count at 0.
//
// Ports:
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low reset (count -> 0)
//   run   - count enable; low clears the count
//   tick  - high on the final cycle of each bit period
module bit_timer
  import reg_serial_tx_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic clr_n,
  input  logic run,
  output logic tick
);

  localparam int TW = cnt_w(DIV);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // With DIV=1 the count never leaves 0, so tick simply follows run.
  assign tick = run && (cnt_q == TW'(DIV - 1));

  always_comb begin
    cnt_d = '0;
    if (run && !tick) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_serial_tx.sv
// Serial transmitter: loads an N-bit word and sends start(0), N data bits MSB-first, stop(1).
// Latency: first start-bit cycle is the cycle after accept; frame lasts (N+2)*DIV cycles, done in the following cycle.
// Backpressure: ready=0 while a frame is in progress; load is then ignored (no queuing).
//
// Ports:
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low reset, aborts any frame
//   load  - request to transmit d (accepted when ready)
//   d     - N-bit parallel word
//   ready - high in IDLE
//   tx    - registered serial line, idle high
//   busy  - inverse of ready
//   done  - one-cycle pulse in the first IDLE cycle after a frame
module reg_serial_tx
  import reg_serial_tx_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int DIV = DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int IW = cnt_w(N);

  state_t        state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic          run;
  logic          tick;
  logic [N-1:0]  sh_shift;

  assign run      = (state_q != IDLE);
  assign ready    = (state_q == IDLE);
  assign busy     = ~ready;
  assign tx       = tx_q;
  assign done     = done_q;
  // Shifting the whole register (rather than slicing) keeps N=1 legal.
  assign sh_shift = sh_q << 1;

  bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk   (clk),
    .clr_n (clr_n),
    .run   (run),
    .tick  (tick)
  );

  // tx_d is always the value for the *next* bit period, so tx only moves on
  // the edge that ends a period (tick) or on the accept edge.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          sh_d    = d;
          idx_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = sh_q[N-1];
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IW'(N - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sh_d  = sh_shift;
            tx_d  = sh_shift[N-1];
            idx_d = idx_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          tx_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Testbench for reg_serial_tx: N=8/DIV=4 instance driven from a frame table,
// plus an N=1/DIV=1 instance and hand-written reset / idle sequences.
module tb_reg_serial_tx;

  localparam int DIVA = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;

  logic       load_a = 1'b0;
  logic [7:0] d_a = 8'h00;
  logic       ready_a, tx_a, busy_a, done_a;

  logic       load_b = 1'b0;
  logic [0:0] d_b = 1'b0;
  logic       ready_b, tx_b, busy_b, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_serial_tx #(.N(8), .DIV(4)) dut_a (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (load_a),
    .d     (d_a),
    .ready (ready_a),
    .tx    (tx_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  reg_serial_tx #(.N(1), .DIV(1)) dut_b (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (load_b),
    .d     (d_b),
    .ready (ready_b),
    .tx    (tx_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  typedef struct {
    logic [7:0] d;
    bit         noise;  // hold load=1, d=FF during the frame
    bit         chain;  // load the next entry in this frame's done cycle
    logic [9:0] exp;    // expected frame, start bit in [9]
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Caller has load_a=1 and d_a=dv applied before the accepting edge.
  task automatic send_a(input logic [7:0] dv, input bit noise, input logic [9:0] exp,
                        input bit chain, input logic [7:0] nd);
    @(posedge clk);
    for (int k = 0; k < 10 * DIVA; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (noise) begin
          load_a = 1'b1;
          d_a    = 8'hFF;
        end else begin
          load_a = 1'b0;
          d_a    = ~dv;
        end
      end
      chk("frame_tx", tx_a, exp[9 - k / DIVA]);
      chk("frame_busy", busy_a, 1);
      chk("frame_done", done_a, 0);
    end
    @(negedge clk);
    chk("done_pulse", done_a, 1);
    chk("done_ready", ready_a, 1);
    chk("done_tx", tx_a, 1);
    if (chain) begin
      load_a = 1'b1;
      d_a    = nd;
    end else begin
      load_a = 1'b0;
      @(negedge clk);
      chk("done_single", done_a, 0);
      chk("idle_ready", ready_a, 1);
      chk("idle_tx", tx_a, 1);
    end
  endtask

  // Caller has load_b=1 and d_b applied before the accepting edge.
  task automatic send_b(input logic [2:0] exp);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) load_b = 1'b0;
      chk("b_tx", tx_b, exp[2 - k]);
      chk("b_done_low", done_b, 0);
    end
    @(negedge clk);
    chk("b_done", done_b, 1);
    chk("b_ready", ready_b, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit chained;

    tbl[0] = '{d: 8'hA5, noise: 1'b0, chain: 1'b0, exp: 10'b0101001011};
    tbl[1] = '{d: 8'hA5, noise: 1'b1, chain: 1'b1, exp: 10'b0101001011};
    tbl[2] = '{d: 8'h3C, noise: 1'b0, chain: 1'b0, exp: 10'b0001111001};
    tbl[3] = '{d: 8'hFF, noise: 1'b0, chain: 1'b0, exp: 10'b0111111111};
    tbl[4] = '{d: 8'h00, noise: 1'b0, chain: 1'b0, exp: 10'b0000000001};

    // Reset values, checked between clock edges.
    #2 clr_n = 1'b0;
    #1;
    chk("rst_ready", ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_tx", tx_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_ready_b", ready_b, 1);
    repeat (2) @(negedge clk);

    // Release with a load already pending on B: accepted on the first edge.
    clr_n  = 1'b1;
    load_b = 1'b1;
    d_b    = 1'b1;
    send_b(3'b011);
    load_b = 1'b1;
    d_b    = 1'b0;
    send_b(3'b001);

    // A has seen load=0 since reset: stays idle.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_tx_hold", tx_a, 1);
      chk("idle_done_hold", done_a, 0);
      chk("idle_busy_hold", busy_a, 0);
    end

    // Frame table, including a held-load frame chained back-to-back into 0x3C.
    chained = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!chained) begin
        @(negedge clk);
        chk("pre_ready", ready_a, 1);
        load_a = 1'b1;
        d_a    = tbl[i].d;
      end
      send_a(tbl[i].d, tbl[i].noise, tbl[i].exp, tbl[i].chain,
             (i < 4) ? tbl[(i < 4) ? i + 1 : i].d : 8'h00);
      chained = tbl[i].chain;
    end

    // Reset in the middle of DATA: outputs go idle with no clock edge.
    @(negedge clk);
    load_a = 1'b1;
    d_a    = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    load_a = 1'b0;
    chk("mid_start_tx", tx_a, 0);
    repeat (14) @(negedge clk);
    chk("mid_busy", busy_a, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_tx", tx_a, 1);
    chk("abort_ready", ready_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("post_abort_done", done_a, 0);
      chk("post_abort_tx", tx_a, 1);
    end
    @(negedge clk);
    load_a = 1'b1;
    d_a    = 8'h01;
    send_a(8'h01, 1'b0, 10'b0000000011, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
